// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with writeback bypass on capture, EX operand forwarding and load-use detection.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic        id_use_imm_i,
  input  logic [5:0]  id_aluop_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_rd_we_i,
  input  logic        id_is_load_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic        mem_rd_we_i,
  input  logic [31:0] mem_result_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        wb_rd_we_i,
  input  logic [31:0] wb_result_i,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [5:0]  aluop_o,
  output logic [31:0] store_data_o,
  output logic        ex_valid_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic        ex_rd_we_o,
  output logic        load_use_o
);
  logic        ex_valid, use_imm, rd_we, is_load;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [5:0]  aluop;
  logic [31:0] fwd1, fwd2;

  function automatic logic wb_hit(input logic [4:0] a);
    return wb_rd_we_i && a != 5'd0 && a == wb_rd_addr_i;
  endfunction

  function automatic logic mem_hit(input logic [4:0] a);
    return mem_rd_we_i && a != 5'd0 && a == mem_rd_addr_i;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid <= 1'b0;
      rs1_addr <= '0;
      rs2_addr <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      imm      <= '0;
      use_imm  <= 1'b0;
      aluop    <= '0;
      rd_addr  <= '0;
      rd_we    <= 1'b0;
      is_load  <= 1'b0;
    end else if (flush_i || (!stall_i && load_use_o)) begin
      ex_valid <= 1'b0;
      rd_we    <= 1'b0;
      is_load  <= 1'b0;
    end else if (!stall_i) begin
      ex_valid <= id_valid_i;
      rs1_addr <= id_rs1_addr_i;
      rs2_addr <= id_rs2_addr_i;
      rs1_data <= wb_hit(id_rs1_addr_i) ? wb_result_i : id_rs1_data_i;
      rs2_data <= wb_hit(id_rs2_addr_i) ? wb_result_i : id_rs2_data_i;
      imm      <= id_imm_i;
      use_imm  <= id_use_imm_i;
      aluop    <= id_aluop_i;
      rd_addr  <= id_rd_addr_i;
      rd_we    <= id_rd_we_i;
      is_load  <= id_is_load_i;
    end
  end

  // MEM is the younger producer, so it takes precedence over WB
  assign fwd1 = mem_hit(rs1_addr) ? mem_result_i : wb_hit(rs1_addr) ? wb_result_i : rs1_data;
  assign fwd2 = mem_hit(rs2_addr) ? mem_result_i : wb_hit(rs2_addr) ? wb_result_i : rs2_data;

  assign op1_o        = fwd1;
  assign op2_o        = use_imm ? imm : fwd2;
  assign store_data_o = fwd2;
  assign aluop_o      = aluop;
  assign ex_valid_o   = ex_valid;
  assign ex_rd_addr_o = rd_addr;
  assign ex_rd_we_o   = rd_we & ex_valid;
  assign load_use_o   = ex_valid & is_load & rd_we & (rd_addr != 5'd0) & id_valid_i &
                        ((id_rs1_addr_i == rd_addr) | (id_rs2_addr_i == rd_addr));
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, bypass, forwarding, hazard and reset behaviour.
module tb_id_ex_stage;
  logic        clk_i = 1'b0, rst_n_i;
  logic        stall_i, flush_i, id_valid_i, id_use_imm_i, id_rd_we_i, id_is_load_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, mem_rd_addr_i, wb_rd_addr_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, mem_result_i, wb_result_i;
  logic [5:0]  id_aluop_i;
  logic        mem_rd_we_i, wb_rd_we_i;
  logic [31:0] op1_o, op2_o, store_data_o;
  logic [5:0]  aluop_o;
  logic        ex_valid_o, ex_rd_we_o, load_use_o;
  logic [4:0]  ex_rd_addr_o;
  int total = 0, bad = 0;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_use_imm_i(id_use_imm_i), .id_aluop_i(id_aluop_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rd_we_i(id_rd_we_i), .id_is_load_i(id_is_load_i), .mem_rd_addr_i(mem_rd_addr_i),
    .mem_rd_we_i(mem_rd_we_i), .mem_result_i(mem_result_i), .wb_rd_addr_i(wb_rd_addr_i),
    .wb_rd_we_i(wb_rd_we_i), .wb_result_i(wb_result_i), .op1_o(op1_o), .op2_o(op2_o),
    .aluop_o(aluop_o), .store_data_o(store_data_o), .ex_valid_o(ex_valid_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_we_o(ex_rd_we_o), .load_use_o(load_use_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0; id_valid_i = 0; id_use_imm_i = 0; id_rd_we_i = 0; id_is_load_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0; id_rs1_data_i = 0; id_rs2_data_i = 0;
    id_imm_i = 0; id_aluop_i = 0; mem_rd_addr_i = 0; mem_rd_we_i = 0; mem_result_i = 0;
    wb_rd_addr_i = 0; wb_rd_we_i = 0; wb_result_i = 0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                       input logic [31:0] d2, input logic [5:0] op, input logic [4:0] rd);
    id_valid_i = 1; id_rs1_addr_i = rs1; id_rs1_data_i = d1; id_rs2_addr_i = rs2;
    id_rs2_data_i = d2; id_aluop_i = op; id_rd_addr_i = rd; id_rd_we_i = 1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    idle();
    rst_n_i = 0;
    instr(5'd5, 32'h1234, 5'd6, 32'h5678, 6'd9, 5'd8);
    #22;
    chk("rst_valid", 32'(ex_valid_o), 0);
    chk("rst_we", 32'(ex_rd_we_o), 0);
    chk("rst_rd", 32'(ex_rd_addr_o), 0);
    chk("rst_aluop", 32'(aluop_o), 0);
    chk("rst_op1", op1_o, 0);
    chk("rst_op2", op2_o, 0);
    chk("rst_store", store_data_o, 0);
    chk("rst_lu", 32'(load_use_o), 0);
    @(negedge clk_i);
    rst_n_i = 1;
    idle();
    // forwarding priority MEM > WB > stored
    instr(5'd5, 32'h10, 5'd1, 32'h0, 6'd9, 5'd8);
    step();
    idle();
    mem_rd_addr_i = 5; mem_rd_we_i = 1; mem_result_i = 32'h99;
    wb_rd_addr_i = 5; wb_rd_we_i = 1; wb_result_i = 32'h77;
    #1;
    chk("fwd_mem", op1_o, 32'h99);
    chk("ex_valid", 32'(ex_valid_o), 1);
    chk("ex_aluop", 32'(aluop_o), 9);
    chk("ex_rd", 32'(ex_rd_addr_o), 8);
    chk("ex_we", 32'(ex_rd_we_o), 1);
    mem_rd_we_i = 0;
    #1 chk("fwd_wb", op1_o, 32'h77);
    wb_rd_we_i = 0;
    #1 chk("fwd_none", op1_o, 32'h10);
    // WB bypass at capture
    idle();
    instr(5'd3, 32'h1, 5'd4, 32'h22, 6'd0, 5'd9);
    wb_rd_addr_i = 3; wb_rd_we_i = 1; wb_result_i = 32'hABCD;
    step();
    wb_rd_we_i = 0;
    #1;
    chk("cap_byp", op1_o, 32'hABCD);
    chk("cap_nobyp", op2_o, 32'h22);
    // immediate operand with forwarded store data
    idle();
    instr(5'd1, 32'h0, 5'd6, 32'h5, 6'd0, 5'd10);
    id_use_imm_i = 1; id_imm_i = 32'hFFFF_FFF0;
    step();
    idle();
    mem_rd_addr_i = 6; mem_rd_we_i = 1; mem_result_i = 32'h1234;
    #1;
    chk("imm_op2", op2_o, 32'hFFFF_FFF0);
    chk("imm_store", store_data_o, 32'h1234);
    // x0 never forwards
    idle();
    instr(5'd0, 32'h0, 5'd0, 32'h0, 6'd0, 5'd11);
    step();
    mem_rd_addr_i = 0; mem_rd_we_i = 1; mem_result_i = 32'hDEAD;
    #1 chk("x0_op1", op1_o, 0);
    idle();
    instr(5'd0, 32'h33, 5'd0, 32'h0, 6'd0, 5'd11);
    wb_rd_addr_i = 0; wb_rd_we_i = 1; wb_result_i = 32'hBEEF;
    step();
    mem_rd_addr_i = 0; mem_rd_we_i = 1; mem_result_i = 32'hDEAD;
    #1 chk("x0_stored", op1_o, 32'h33);
    // load-use hazard
    idle();
    instr(5'd1, 32'h0, 5'd2, 32'h0, 6'd0, 5'd7);
    id_is_load_i = 1;
    step();
    idle();
    instr(5'd1, 32'h0, 5'd7, 32'h0, 6'd0, 5'd12);
    #1 chk("lu_hit", 32'(load_use_o), 1);
    id_valid_i = 0;
    #1 chk("lu_novalid", 32'(load_use_o), 0);
    id_valid_i = 1;
    step();
    chk("lu_bubble_valid", 32'(ex_valid_o), 0);
    chk("lu_bubble_we", 32'(ex_rd_we_o), 0);
    chk("lu_clear", 32'(load_use_o), 0);
    // flush beats stall
    idle();
    instr(5'd2, 32'h44, 5'd1, 32'h0, 6'd3, 5'd9);
    step();
    chk("pre_flush_valid", 32'(ex_valid_o), 1);
    stall_i = 1; flush_i = 1;
    step();
    chk("flush_valid", 32'(ex_valid_o), 0);
    chk("flush_we", 32'(ex_rd_we_o), 0);
    // stall holds for three cycles
    idle();
    instr(5'd2, 32'h44, 5'd1, 32'h0, 6'd3, 5'd9);
    step();
    instr(5'd13, 32'h999, 5'd14, 32'h888, 6'd5, 5'd12);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_op1", op1_o, 32'h44);
      chk("stall_aluop", 32'(aluop_o), 3);
      chk("stall_rd", 32'(ex_rd_addr_o), 9);
      chk("stall_valid", 32'(ex_valid_o), 1);
    end
    mem_rd_addr_i = 2; mem_rd_we_i = 1; mem_result_i = 32'h55;
    #1 chk("stall_fwd", op1_o, 32'h55);
    // asynchronous reset mid-stall
    #2 rst_n_i = 0;
    #1;
    chk("arst_valid", 32'(ex_valid_o), 0);
    chk("arst_op1", op1_o, 0);
    chk("arst_aluop", 32'(aluop_o), 0);
    chk("arst_rd", 32'(ex_rd_addr_o), 0);
    idle();
    #10 rst_n_i = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk_i (input, 1, rising-edge clock) and rst_n_i (input, 1, async active-low reset).
REQ-002 stall_i  input  1  hold ID/EX register contents.
REQ-003 flush_i  input  1  kill the instruction entering EX (bubble).
REQ-004 id_valid_i  input  1  ID holds a real instruction.
REQ-005 id_rs1_addr_i  input  5  source register 1 index.
REQ-006 id_rs2_addr_i  input  5  source register 2 index.
REQ-007 id_rs1_data_i  input  32  register-file read data, rs1.
REQ-008 id_rs2_data_i  input  32  register-file read data, rs2.
REQ-009 id_imm_i  input  32  sign-extended immediate.
REQ-010 id_use_imm_i  input  1  operand 2 is the immediate.
REQ-011 id_aluop_i  input  6  ALU opcode (0=ADD ... 9=SUB).
REQ-012 id_rd_addr_i  input  5  destination register index.
REQ-013 id_rd_we_i  input  1  instruction writes rd.
REQ-014 id_is_load_i  input  1  instruction is a load.
REQ-015 mem_rd_addr_i  input  5  EX/MEM destination index.
REQ-016 mem_rd_we_i  input  1  EX/MEM writes rd, already valid-qualified.
REQ-017 mem_result_i  input  32  EX/MEM ALU result.
REQ-018 wb_rd_addr_i  input  5  MEM/WB destination index.
REQ-019 wb_rd_we_i  input  1  MEM/WB writes rd, already valid-qualified.
REQ-020 wb_result_i  input  32  MEM/WB writeback data.
REQ-021 op1_o  output  32  ALU operand 1.
REQ-022 op2_o  output  32  ALU operand 2.
REQ-023 aluop_o  output  6  registered ALU opcode.
REQ-024 store_data_o  output  32  forwarded rs2 value for stores.
REQ-025 ex_valid_o  output  1  EX holds a real instruction.
REQ-026 ex_rd_addr_o  output  5  registered rd index.
REQ-027 ex_rd_we_o  output  1  registered write enable, gated by ex_valid_o.
REQ-028 load_use_o  output  1  load-use hazard; upstream stalls PC and IF/ID.

Function
REQ-029 Register update on rising clk_i, priority: flush_i > stall_i > load_use_o bubble > capture.
REQ-030 flush_i=1: ex_valid<=0, stored rd_we<=0, stored is_load<=0; other fields don't-care, held.
REQ-031 stall_i=1 (flush_i=0): every stored field holds, including rs addresses and data.
REQ-032 load_use_o=1, stall_i=0, flush_i=0: bubble captured (ex_valid<=0, rd_we<=0, is_load<=0).
REQ-033 Capture: valid, rs1/rs2 addr+data, imm, use_imm, aluop, rd, rd_we, is_load latched from id_*; ex_valid<=id_valid_i.
REQ-034 Capture bypass: if wb_rd_we_i, wb_rd_addr_i!=0 and wb_rd_addr_i==id_rsN_addr_i, latch wb_result_i instead of id_rsN_data_i (per source).
REQ-035 Forwarding, combinational per source N on stored rsN: mem match (mem_rd_we_i, addr!=0, equal) -> mem_result_i; else wb match -> wb_result_i; else stored data. MEM wins over WB.
REQ-036 Index 0 never forwards; x0 reads stored data.
REQ-037 op1_o = fwd rs1; op2_o = stored use_imm ? stored imm : fwd rs2; store_data_o = fwd rs2 always.
REQ-038 load_use_o = ex_valid & is_load & rd_we & rd!=0 & id_valid_i & (id_rs1_addr_i==rd | id_rs2_addr_i==rd); combinational, rs2 compared conservatively.
REQ-039 Single-cycle latency: capture at edge N drives op1_o/op2_o/aluop_o during cycle N+1.

Reset
REQ-040 rst_n_i=0 asynchronously clears all stored fields: ex_valid_o=0, ex_rd_we_o=0, ex_rd_addr_o=0, aluop_o=0 (ADD), op1_o=op2_o=store_data_o=0, load_use_o=0; reset mid-stall or mid-bubble discards the instruction.

Verification
REQ-041 rs1=x5 data 0x10, mem_rd x5 we=1 result 0x99, wb_rd x5 result 0x77 -> op1_o=0x99.
REQ-042 EX holds load to x7; ID valid reads rs2=x7 -> load_use_o=1; next edge ex_valid_o=0, ex_rd_we_o=0.
REQ-043 ID rs1=x3 data 0x1, same cycle wb writes x3=0xABCD, no MEM match -> after edge op1_o=0xABCD.
REQ-044 Capture use_imm=1, imm 0xFFFFFFF0, rs2 forwardable -> op2_o=0xFFFFFFF0, store_data_o=forwarded rs2.
REQ-045 stall_i=1 and flush_i=1 same edge -> ex_valid_o=0; stall_i=1 alone 3 cycles -> outputs unchanged.
REQ-046 mem_rd_addr_i=0, mem_rd_we_i=1, rs1=x0 stored 0 -> op1_o=0.
